// File: rtl/xcorr_stream_pkg.sv
// Shared constants for the streaming bit correlator.
// Holds the default window length / index width and the derived
// correlation-count width used by the top and the popcount tree.
package xcorr_stream_pkg;

  localparam int NDATA_DEF     = 64;
  localparam int IDXW_DEF      = 16;
  localparam int NDATA_LOG_DEF = $clog2(NDATA_DEF);
  localparam int CW_DEF        = NDATA_LOG_DEF + 1;

  // Width needed to count 0..ndata matching bits.
  function automatic int corr_width(input int ndata);
    return $clog2(ndata) + 1;
  endfunction

endpackage

// File: rtl/xcorr_stream_bintree.sv
// Purpose: population count of an N-bit vector as a pairwise adder tree.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of in_bits.
//
// Ports:
//   in_bits  N-bit vector to count
//   ones     number of set bits in in_bits (0..N)
module xcorr_stream_bintree
  import xcorr_stream_pkg::*;
#(
  parameter int N = NDATA_DEF,
  parameter int W = CW_DEF
)(
  input  logic [N-1:0] in_bits,
  output logic [W-1:0] ones
);

  // In-place reduction: each level halves the live node count. Node i of
  // the next level is written only after nodes 2i and 2i+1 have been read,
  // so a single array is enough.
  always_comb begin
    logic [W-1:0] node [N];
    for (int i = 0; i < N; i++) begin
      node[i] = W'(in_bits[i]);
    end
    for (int n = N; n > 1; n = n / 2) begin
      for (int i = 0; i < n / 2; i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    ones = node[0];
  end

endmodule

// File: rtl/xcorr_stream.sv
// Purpose: slide a serial bit stream through an NDATA-bit window, count bits
//          matching a loaded reference, flag threshold hits, and track the peak.
// Latency: 2 edges from accepted sample to corr_valid; backpressure: none, one result per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ref_load, ref_din   load reference (bit 0 pairs with newest sample), restart
//   din_valid, din      serial sample strobe and data
//   thresh              hit threshold, sampled on the result edge
//   clear_peak          zero the peak tracker
//   corr_valid/corr/hit one-cycle result: matching-bit count and threshold flag
//   peak/peak_idx/peak_valid  best result since last clear and its newest-sample index
module xcorr_stream
  import xcorr_stream_pkg::*;
#(
  parameter int  NDATA     = NDATA_DEF,
  parameter int  IDXW      = IDXW_DEF,
  localparam int NDATA_LOG = $clog2(NDATA),
  localparam int CW        = NDATA_LOG + 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ref_load,
  input  logic [NDATA-1:0] ref_din,
  input  logic             din_valid,
  input  logic             din,
  input  logic [CW-1:0]    thresh,
  input  logic             clear_peak,
  output logic             corr_valid,
  output logic [CW-1:0]    corr,
  output logic             hit,
  output logic [CW-1:0]    peak,
  output logic [IDXW-1:0]  peak_idx,
  output logic             peak_valid
);

  logic [NDATA-1:0] win;
  logic [NDATA-1:0] refp;
  logic [CW-1:0]    fill;
  logic [CW-1:0]    fill_nxt;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  s1_idx;
  logic             s1_vld;
  logic             res_vld;
  logic [CW-1:0]    pop;

  assign fill_nxt = (fill == CW'(NDATA)) ? fill : fill + 1'b1;

  // A reference reload in the result cycle kills the in-flight window.
  assign res_vld = s1_vld & ~ref_load;

  xcorr_stream_bintree #(
    .N (NDATA),
    .W (CW)
  ) u_pop (
    .in_bits (~(win ^ refp)),
    .ones    (pop)
  );

  // Stage 1: window shift, fill/index bookkeeping. ref_load takes priority
  // over a coincident sample, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win    <= '0;
      refp   <= '0;
      fill   <= '0;
      idx    <= '0;
      s1_idx <= '0;
      s1_vld <= 1'b0;
    end else if (ref_load) begin
      refp   <= ref_din;
      fill   <= '0;
      s1_vld <= 1'b0;
    end else if (din_valid) begin
      win    <= {win[NDATA-2:0], din};
      fill   <= fill_nxt;
      idx    <= idx + 1'b1;
      s1_idx <= idx;
      s1_vld <= (fill_nxt == CW'(NDATA));
    end else begin
      s1_vld <= 1'b0;
    end
  end

  // Stage 2: register the count and hit, update the peak tracker.
  // A clear on the result edge wins over that result for the tracker only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_valid <= 1'b0;
      corr       <= '0;
      hit        <= 1'b0;
      peak       <= '0;
      peak_idx   <= '0;
      peak_valid <= 1'b0;
    end else begin
      corr_valid <= res_vld;
      hit        <= res_vld && (pop >= thresh);
      if (res_vld) begin
        corr <= pop;
      end
      if (ref_load || clear_peak) begin
        peak       <= '0;
        peak_idx   <= '0;
        peak_valid <= 1'b0;
      end else if (res_vld && (!peak_valid || (pop > peak))) begin
        // Strict '>' keeps the earliest index on ties.
        peak       <= pop;
        peak_idx   <= s1_idx;
        peak_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xcorr_stream.sv
module tb_xcorr_stream;

  localparam int NDATA = 8;
  localparam int IDXW  = 16;
  localparam int CW    = 4;

  logic            clk;
  logic            rst_n;
  logic            ref_load;
  logic [NDATA-1:0] ref_din;
  logic            din_valid;
  logic            din;
  logic [CW-1:0]   thresh;
  logic            clear_peak;
  logic            corr_valid;
  logic [CW-1:0]   corr;
  logic            hit;
  logic [CW-1:0]   peak;
  logic [IDXW-1:0] peak_idx;
  logic            peak_valid;

  xcorr_stream #(.NDATA(NDATA), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ref_load   (ref_load),
    .ref_din    (ref_din),
    .din_valid  (din_valid),
    .din        (din),
    .thresh     (thresh),
    .clear_peak (clear_peak),
    .corr_valid (corr_valid),
    .corr       (corr),
    .hit        (hit),
    .peak       (peak),
    .peak_idx   (peak_idx),
    .peak_valid (peak_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result, tagged with the clock edge on which it must appear.
  typedef struct {
    int edge_n;
    int corr;
    bit hit;
    int pk;
    int pk_idx;
    bit pk_vld;
  } exp_t;
  exp_t sb[$];

  // Reference model state: samples since last (re)start, reference, index,
  // a result awaiting its report edge, and the peak tracker.
  bit       hist[$];
  bit [7:0] m_ref;
  int       m_idx;
  bit       pend;
  int       pend_corr;
  int       pend_idx;
  int       pk;
  int       pk_idx;
  bit       pk_vld;

  task automatic model_reset();
    hist.delete();
    m_ref  = '0;
    m_idx  = 0;
    pend   = 1'b0;
    pk     = 0;
    pk_idx = 0;
    pk_vld = 1'b0;
  endtask

  // Drive one clock edge worth of inputs and advance the model over it.
  task automatic drive(input bit ld, input bit [7:0] rd, input bit v,
                       input bit d, input int th, input bit clr);
    exp_t x;
    int   e;
    @(negedge clk);
    ref_load   = ld;
    ref_din    = rd;
    din_valid  = v;
    din        = d;
    thresh     = 4'(th);
    clear_peak = clr;
    e = edge_cnt + 1;
    if (ld) begin
      pk = 0; pk_idx = 0; pk_vld = 1'b0;
    end else begin
      if (clr) begin
        pk = 0; pk_idx = 0; pk_vld = 1'b0;
      end else if (pend && (!pk_vld || pend_corr > pk)) begin
        pk = pend_corr; pk_idx = pend_idx; pk_vld = 1'b1;
      end
      if (pend) begin
        x.edge_n = e;
        x.corr   = pend_corr;
        x.hit    = (pend_corr >= th);
        x.pk     = pk;
        x.pk_idx = pk_idx;
        x.pk_vld = pk_vld;
        sb.push_back(x);
      end
    end
    pend = 1'b0;
    if (ld) begin
      m_ref = rd;
      hist.delete();
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > NDATA) void'(hist.pop_front());
      if (hist.size() == NDATA) begin
        pend      = 1'b1;
        pend_corr = 0;
        for (int j = 0; j < NDATA; j++)
          if (hist[NDATA-1-j] == m_ref[j]) pend_corr++;
        pend_idx  = m_idx;
      end
      m_idx = (m_idx + 1) % 65536;
    end
  endtask

  task automatic idle(input int th);
    drive(1'b0, 8'h00, 1'b0, 1'b0, th, 1'b0);
  endtask

  task automatic feed_byte(input bit [7:0] b, input int th);
    for (int i = NDATA - 1; i >= 0; i--) drive(1'b0, 8'h00, 1'b1, b[i], th, 1'b0);
  endtask

  task automatic drive_rand();
    drive(bit'($urandom_range(0, 49) == 0), 8'($urandom), bit'($urandom_range(0, 3) != 0),
          1'($urandom), int'($urandom_range(0, 15)), bit'($urandom_range(0, 19) == 0));
  endtask

  // Reset pulse placed between two rising edges.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    ref_load = 1'b0; din_valid = 1'b0; din = 1'b0; clear_peak = 1'b0;
    model_reset();
    #1;
    chk("rst_corr_valid", int'(corr_valid), 0);
    chk("rst_corr",       int'(corr),       0);
    chk("rst_hit",        int'(hit),        0);
    chk("rst_peak",       int'(peak),       0);
    chk("rst_peak_idx",   int'(peak_idx),   0);
    chk("rst_peak_valid", int'(peak_valid), 0);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every corr_valid must match the oldest expected result and
  // arrive on its expected edge; expected results must not be skipped.
  exp_t mx;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_n < edge_cnt) begin
      mx = sb.pop_front();
      chk("missing_result_edge", edge_cnt, mx.edge_n);
    end
    if (corr_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_corr_valid", int'(corr_valid), 0);
      end else begin
        mx = sb.pop_front();
        chk("result_edge", edge_cnt,         mx.edge_n);
        chk("corr",        int'(corr),       mx.corr);
        chk("hit",         int'(hit),        int'(mx.hit));
        chk("peak",        int'(peak),       mx.pk);
        chk("peak_idx",    int'(peak_idx),   mx.pk_idx);
        chk("peak_valid",  int'(peak_valid), int'(mx.pk_vld));
      end
    end else begin
      chk("hit_without_valid", int'(hit), 0);
    end
  end

  initial begin
    rst_n = 1'b0;
    ref_load = 1'b0; ref_din = '0; din_valid = 1'b0; din = 1'b0;
    thresh = '0; clear_peak = 1'b0;
    model_reset();
    #1;
    chk("init_corr_valid", int'(corr_valid), 0);
    chk("init_corr",       int'(corr),       0);
    chk("init_hit",        int'(hit),        0);
    chk("init_peak",       int'(peak),       0);
    chk("init_peak_idx",   int'(peak_idx),   0);
    chk("init_peak_valid", int'(peak_valid), 0);
    #12;
    rst_n = 1'b1;

    // Perfect match, back-to-back feed.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 7, 1'b0);
    feed_byte(8'hA5, 7);
    idle(7);
    @(posedge clk); #1;
    chk("match_corr_valid", int'(corr_valid), 1);
    chk("match_corr",       int'(corr),       8);
    chk("match_hit",        int'(hit),        1);
    chk("match_peak",       int'(peak),       8);
    chk("match_peak_idx",   int'(peak_idx),   7);

    // Full mismatch, then three more samples -> three consecutive results.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0);
    feed_byte(8'h5A, 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'($urandom), 1, 1'b0);
    idle(1);
    idle(1);

    // ref_load coincident with the 9th sample.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 4, 1'b0);
    feed_byte(8'($urandom), 4);
    drive(1'b1, 8'h3C, 1'b1, 1'b1, 4, 1'b0);
    @(posedge clk); #1;
    chk("reload_no_corr_valid", int'(corr_valid), 0);
    chk("reload_peak_valid",    int'(peak_valid), 0);
    feed_byte(8'($urandom), 4);
    idle(4);

    // Tie keeps first index, then clear on a result edge.
    drive(1'b1, 8'h00, 1'b0, 1'b0, 3, 1'b0);
    feed_byte(8'hC0, 3);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 3, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b1);
    @(posedge clk); #1;
    chk("clr_corr_valid", int'(corr_valid), 1);
    chk("clr_corr",       int'(corr),       7);
    chk("clr_peak_valid", int'(peak_valid), 0);

    // Reset between sample edge and result edge.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 2, 1'b0);
    feed_byte(8'hA5, 2);
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b1, 1'($urandom), 2, 1'b0);
    idle(2);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2, 1'b0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) drive_rand();

    // Walk the index to just before the wrap, then score a peak at index 0.
    while (m_idx != 16'hFFF8)
      drive(1'b0, 8'h00, 1'b1, 1'($urandom), int'($urandom_range(0, 15)), 1'b0);
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b0);
    idle(1);
    @(posedge clk); #1;
    chk("wrap_peak",       int'(peak),       2);
    chk("wrap_peak_idx",   int'(peak_idx),   0);
    chk("wrap_peak_valid", int'(peak_valid), 1);

    idle(0);
    idle(0);
    idle(0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
